striping_sched: RTL

Lane-merge scheduler for the PCIe physical-layer receive path. It sits between the two per-lane show-ahead FIFOs and the downstream merge logic. It pops the lanes in strict round-robin order, 0 then 1, and emits one registered word per `clk_2f` cycle with a valid flag. It handles lane starvation, single-lane mode and a stall watchdog. Word order on the output is guaranteed to match the striping order at the transmitter.

---
 rtl/pcie_phy_pkg.sv | 21 ++
 rtl/striping_sched_stall_watchdog.sv | 44 ++++
 rtl/striping_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY receive-path types: scheduler state encoding and lane index.
package pcie_phy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2,
        ERROR  = 2'd3
    } sched_state_e;

    typedef logic lane_idx_t;

    localparam lane_idx_t LANE0 = 1'b0;
    localparam lane_idx_t LANE1 = 1'b1;

    // Map a lane index onto the serve state that handles it.
    function automatic sched_state_e serve_state(input lane_idx_t lane);
        return (lane == LANE1) ? SERVE1 : SERVE0;
    endfunction

endpackage

// File: rtl/striping_sched_stall_watchdog.sv
// Saturating starvation counter; hit flags the increment that reaches STALL_MAX.
module stall_watchdog #(
    parameter int unsigned STALL_MAX = 15
) (
    input  logic clk_2f,
    input  logic reset_L,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [7:0] MAX_C = 8'(STALL_MAX);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins, increment saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        hit   = 1'b0;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (inc) begin
            hit = (cnt_q >= (MAX_C - 8'd1));
            if (cnt_q < MAX_C) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/striping_sched.sv
// Two-lane round-robin merge scheduler with single-lane mode and stall watchdog.
module striping_sched
    import pcie_phy_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned STALL_MAX = 15
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic              enable,
    input  logic              single_lane,
    input  logic [DATA_W-1:0] lane0_data,
    input  logic              lane0_empty,
    output logic              lane0_pop,
    input  logic [DATA_W-1:0] lane1_data,
    input  logic              lane1_empty,
    output logic              lane1_pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              sel_out,
    output logic [CNT_W-1:0]  word_count,
    output logic              stall_err
);

    sched_state_e      state_q, state_d;
    lane_idx_t         ptr_q, ptr_d;
    logic              single_q, single_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    lane_idx_t         sel_q, sel_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    lane_idx_t         cur_lane_s;
    logic              cur_empty_s;
    logic [DATA_W-1:0] cur_data_s;
    logic              serving_s;
    logic              wd_inc_s;
    logic              wd_hit_s;

    // Selected-lane view shared by the pop decode and the state logic.
    always_comb begin
        cur_lane_s  = (state_q == SERVE1) ? LANE1 : LANE0;
        cur_empty_s = (cur_lane_s == LANE1) ? lane1_empty : lane0_empty;
        cur_data_s  = (cur_lane_s == LANE1) ? lane1_data : lane0_data;
        serving_s   = (state_q == SERVE0) || (state_q == SERVE1);
        wd_inc_s    = serving_s && enable && cur_empty_s;
    end

    // Pop decode: only the served lane, only when enabled and non-empty.
    always_comb begin
        lane0_pop = 1'b0;
        lane1_pop = 1'b0;
        if (serving_s && enable && !cur_empty_s) begin
            lane0_pop = (cur_lane_s == LANE0);
            lane1_pop = (cur_lane_s == LANE1);
        end else begin
            lane0_pop = 1'b0;
            lane1_pop = 1'b0;
        end
    end

    // Any cycle that is not a starved, enabled serve cycle restarts the watchdog.
    stall_watchdog #(
        .STALL_MAX(STALL_MAX)
    ) u_wdog (
        .clk_2f (clk_2f),
        .reset_L(reset_L),
        .clr    (!wd_inc_s),
        .inc    (wd_inc_s),
        .hit    (wd_hit_s)
    );

    // Next-state and output-register computation.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        single_d = single_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        sel_d    = sel_q;
        count_d  = count_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                single_d = single_lane;
                if (enable) begin
                    state_d = serve_state(ptr_q);
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE0, SERVE1: begin
                if (!enable) begin
                    // Remember the lane so the striping order resumes exactly.
                    state_d = IDLE;
                    ptr_d   = cur_lane_s;
                end else if (!cur_empty_s) begin
                    data_d  = cur_data_s;
                    valid_d = 1'b1;
                    sel_d   = cur_lane_s;
                    count_d = count_q + CNT_W'(1);
                    if (single_q || (cur_lane_s == LANE1)) begin
                        state_d = SERVE0;
                    end else begin
                        state_d = SERVE1;
                    end
                end else if (wd_hit_s) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ERROR: begin
                if (!enable) begin
                    state_d = IDLE;
                    ptr_d   = LANE0;
                end else begin
                    state_d = ERROR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            ptr_q    <= LANE0;
            single_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sel_q    <= LANE0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            single_q <= single_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign sel_out    = sel_q;
    assign word_count = count_q;
    assign stall_err  = err_q;

endmodule
